// File: rtl/gc_server_pkg.sv
// Shared constants for the global counter server and its requesters.
package gc_server_pkg;

    localparam int unsigned N_CORE    = 4;
    localparam int unsigned GC_WIDTH  = 16;
    localparam int unsigned ROB_WIDTH = 6;

endpackage : gc_server_pkg

// File: rtl/gc_server_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           enable,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    int unsigned idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        if (enable) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = (32'(ptr) + k) % N;
                if (!any && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_id   = IDW'(idx);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/gc_server.sv
// Global counter owner: hands out one gc value per cycle to round-robin requesters.
module gc_server #(
    parameter int unsigned N_CORE = gc_server_pkg::N_CORE,
    parameter int unsigned IDW    = (N_CORE > 1) ? $clog2(N_CORE) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_CORE-1:0]                    req_valid,
    output logic [N_CORE-1:0]                    req_ready,
    output logic [gc_server_pkg::GC_WIDTH-1:0]   gc,
    input  logic                                 set_valid,
    input  logic [gc_server_pkg::GC_WIDTH-1:0]   set_value,
    output logic                                 grant_valid,
    output logic [IDW-1:0]                       grant_id
);

    import gc_server_pkg::*;

    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      ptr_d;
    logic [GC_WIDTH-1:0] gc_d;

    // Set and reset both suppress the same-cycle grant.
    rr_arbiter #(
        .N   (N_CORE),
        .IDW (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (!set_valid && !reset),
        .gnt    (req_ready),
        .gnt_id (grant_id),
        .any    (grant_valid)
    );

    always_comb begin
        gc_d  = gc;
        ptr_d = ptr;
        if (set_valid) begin
            gc_d = set_value;
        end else if (grant_valid) begin
            gc_d  = gc + GC_WIDTH'(1);
            ptr_d = (32'(grant_id) == N_CORE - 1) ? '0 : grant_id + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gc  <= '0;
            ptr <= '0;
        end else begin
            gc  <= gc_d;
            ptr <= ptr_d;
        end
    end

endmodule : gc_server
